// File: rtl/adv_timer_counter.sv
// adv_timer_counter: sawtooth/up-down timebase with double-buffered start/end bounds and registered count/valid/end/mode outputs
module adv_timer_counter #(
  parameter int NUM_BITS = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ctrl_active_i,
  input  logic                ctrl_update_i,
  input  logic                ctrl_rst_i,
  input  logic [NUM_BITS-1:0] cfg_start_i,
  input  logic [NUM_BITS-1:0] cfg_end_i,
  input  logic                cfg_sawtooth_i,
  input  logic                input_valid_i,
  output logic [NUM_BITS-1:0] counter_o,
  output logic                output_valid_o,
  output logic                output_end_o,
  output logic                output_sawtooth_o
);
  localparam logic [NUM_BITS-1:0] ONE = NUM_BITS'(1);
  logic [NUM_BITS-1:0] count, act_start, act_end, pend_start, pend_end, rs_start, rs_end, nxt;
  logic dir_up, first, pend_saw, pending, rs_saw;
  logic tick, deg, terminal, restart, idle_apply, turn, nxt_up, nxt_end;
  always_comb begin
    tick = ctrl_active_i & input_valid_i;
    deg = act_start >= act_end;
    terminal = deg | (~first & (output_sawtooth_o ? count >= act_end : ~dir_up & (count <= act_start)));
    restart = tick & pending & terminal;
    idle_apply = pending & ~ctrl_active_i;
    rs_start = ctrl_update_i ? cfg_start_i : pending ? pend_start : act_start;
    rs_end = ctrl_update_i ? cfg_end_i : pending ? pend_end : act_end;
    rs_saw = ctrl_update_i ? cfg_sawtooth_i : pending ? pend_saw : output_sawtooth_o;
    turn = dir_up ? count >= act_end : count <= act_start;
    nxt_up = (output_sawtooth_o | deg | first) ? dir_up : dir_up ^ turn;
    nxt = deg ? act_start :
          first ? count :
          output_sawtooth_o ? (count >= act_end ? act_start : count + ONE) :
          nxt_up ? count + ONE : count - ONE;
    nxt_end = deg | (~first & (output_sawtooth_o ? nxt == act_end : ~nxt_up & (nxt == act_start)));
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
      act_start <= '0;
      act_end <= '1;
      pend_start <= '0;
      pend_end <= '0;
      pend_saw <= 1'b1;
      dir_up <= 1'b1;
      first <= 1'b1;
      pending <= 1'b0;
      counter_o <= '0;
      output_valid_o <= 1'b0;
      output_end_o <= 1'b0;
      output_sawtooth_o <= 1'b1;
    end else begin
      output_valid_o <= tick & ~ctrl_rst_i;
      output_end_o <= 1'b0;
      pending <= ctrl_update_i ? ~ctrl_rst_i : pending & ~(ctrl_rst_i | restart | idle_apply);
      if (ctrl_update_i) begin
        pend_start <= cfg_start_i;
        pend_end <= cfg_end_i;
        pend_saw <= cfg_sawtooth_i;
      end
      if (ctrl_rst_i) begin
        act_start <= rs_start;
        act_end <= rs_end;
        output_sawtooth_o <= rs_saw;
        count <= rs_start;
        dir_up <= 1'b1;
        first <= 1'b1;
      end else if (restart) begin
        act_start <= pend_start;
        act_end <= pend_end;
        output_sawtooth_o <= pend_saw;
        count <= pend_start;
        counter_o <= pend_start;
        dir_up <= 1'b1;
        first <= 1'b0;
        output_end_o <= pend_start >= pend_end;
      end else if (tick) begin
        count <= nxt;
        counter_o <= nxt;
        dir_up <= nxt_up;
        first <= 1'b0;
        output_end_o <= nxt_end;
      end else if (idle_apply) begin
        act_start <= pend_start;
        act_end <= pend_end;
        output_sawtooth_o <= pend_saw;
      end
    end
  end
endmodule

// File: tb/tb_adv_timer_counter.sv
// tb_adv_timer_counter: scoreboard bench for adv_timer_counter with directed scenarios and random stimulus
module tb_adv_timer_counter;
  logic clk = 1'b0, rst_i = 1'b1, ctrl_active_i = 1'b0, ctrl_update_i = 1'b0, ctrl_rst_i = 1'b0;
  logic cfg_sawtooth_i = 1'b1, input_valid_i = 1'b0;
  logic [15:0] cfg_start_i = 16'd0, cfg_end_i = 16'd0, counter_o;
  logic output_valid_o, output_end_o, output_sawtooth_o;
  int checks = 0, failures = 0;
  typedef struct packed { logic [15:0] c; logic e; } exp_t;
  exp_t exp_q[$];
  exp_t mx;
  int obs_c[$], obs_e[$], want_c[$], want_e[$];
  logic [15:0] m_count = 16'd0, m_start = 16'd0, m_end = 16'hffff, m_ps = 16'd0, m_pe = 16'd0;
  bit m_up = 1'b1, m_first = 1'b1, m_saw = 1'b1, m_psaw = 1'b1, m_pend = 1'b0;

  adv_timer_counter #(.NUM_BITS(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .ctrl_active_i(ctrl_active_i), .ctrl_update_i(ctrl_update_i),
    .ctrl_rst_i(ctrl_rst_i), .cfg_start_i(cfg_start_i), .cfg_end_i(cfg_end_i),
    .cfg_sawtooth_i(cfg_sawtooth_i), .input_valid_i(input_valid_i), .counter_o(counter_o),
    .output_valid_o(output_valid_o), .output_end_o(output_end_o), .output_sawtooth_o(output_sawtooth_o)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Reference model: one call per clock edge, using the inputs about to be sampled.
  task automatic model_step();
    bit e, deg;
    e = 1'b0;
    if (rst_i) begin
      m_count = 16'd0; m_start = 16'd0; m_end = 16'hffff; m_saw = 1'b1;
      m_up = 1'b1; m_first = 1'b1; m_pend = 1'b0;
      exp_q.delete();
      return;
    end
    if (ctrl_rst_i) begin
      if (ctrl_update_i) begin
        m_start = cfg_start_i; m_end = cfg_end_i; m_saw = cfg_sawtooth_i;
      end else if (m_pend) begin
        m_start = m_ps; m_end = m_pe; m_saw = m_psaw;
      end
      m_pend = 1'b0; m_count = m_start; m_up = 1'b1; m_first = 1'b1;
      return;
    end
    if (ctrl_active_i && input_valid_i) begin
      deg = m_start >= m_end;
      if (m_pend && (deg || (!m_first && (m_saw ? m_count >= m_end : (!m_up && m_count <= m_start))))) begin
        m_start = m_ps; m_end = m_pe; m_saw = m_psaw; m_pend = 1'b0;
        m_count = m_start; m_up = 1'b1; e = m_start >= m_end;
      end else if (deg) begin
        m_count = m_start; e = 1'b1;
      end else if (m_first) begin
        e = 1'b0;
      end else if (m_saw) begin
        m_count = (m_count >= m_end) ? m_start : 16'(m_count + 1);
        e = m_count == m_end;
      end else begin
        if (m_up && m_count >= m_end) m_up = 1'b0;
        else if (!m_up && m_count <= m_start) m_up = 1'b1;
        m_count = m_up ? 16'(m_count + 1) : 16'(m_count - 1);
        e = !m_up && m_count == m_start;
      end
      m_first = 1'b0;
      exp_q.push_back('{c: m_count, e: e});
    end else if (m_pend && !ctrl_active_i) begin
      m_start = m_ps; m_end = m_pe; m_saw = m_psaw; m_pend = 1'b0;
    end
    if (ctrl_update_i) begin
      m_ps = cfg_start_i; m_pe = cfg_end_i; m_psaw = cfg_sawtooth_i; m_pend = 1'b1;
    end
  endtask

  task automatic drive(bit r, bit a, bit u, bit cr, bit v, int s = 0, int e = 0, bit sw = 1'b1);
    @(negedge clk);
    rst_i = r; ctrl_active_i = a; ctrl_update_i = u; ctrl_rst_i = cr; input_valid_i = v;
    cfg_start_i = 16'(s); cfg_end_i = 16'(e); cfg_sawtooth_i = sw;
    model_step();
  endtask

  task automatic compare_obs(string name);
    drive(0, 1, 0, 0, 0);
    @(posedge clk);
    #2;
    chk({name, " length"}, obs_c.size(), want_c.size());
    for (int i = 0; i < want_c.size() && i < obs_c.size(); i++) begin
      chk($sformatf("%s count[%0d]", name, i), obs_c[i], want_c[i]);
      chk($sformatf("%s end[%0d]", name, i), obs_e[i], want_e[i]);
    end
    obs_c.delete();
    obs_e.delete();
  endtask

  task automatic check_reset(string name);
    @(posedge clk);
    #2;
    chk({name, " counter"}, int'(counter_o), 0);
    chk({name, " valid"}, int'(output_valid_o), 0);
    chk({name, " end"}, int'(output_end_o), 0);
    chk({name, " sawtooth"}, int'(output_sawtooth_o), 1);
  endtask

  always @(posedge clk) begin
    #1;
    if (output_valid_o) begin
      obs_c.push_back(int'(counter_o));
      obs_e.push_back(int'(output_end_o));
    end
    if (exp_q.size() != 0 || output_valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL valid: got 1 expected 0 (count %0d)", counter_o);
      end else begin
        mx = exp_q.pop_front();
        if (!output_valid_o) begin
          failures++;
          $display("FAIL valid: got 0 expected 1 (count %0d)", mx.c);
        end else if (counter_o !== mx.c || output_end_o !== mx.e) begin
          failures++;
          $display("FAIL tick: got count=%0d end=%0d expected count=%0d end=%0d", counter_o, output_end_o, mx.c, mx.e);
        end
      end
    end else begin
      checks++;
      if (output_end_o !== 1'b0) begin
        failures++;
        $display("FAIL end_idle: got %0b expected 0", output_end_o);
      end
    end
    checks++;
    if (output_sawtooth_o !== m_saw) begin
      failures++;
      $display("FAIL sawtooth: got %0b expected %0b", output_sawtooth_o, m_saw);
    end
  end

  initial begin
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    check_reset("reset");
    obs_c.delete(); obs_e.delete();

    drive(0, 0, 1, 1, 0, 0, 3, 1);
    repeat (8) drive(0, 1, 0, 0, 1);
    want_c = '{0, 1, 2, 3, 0, 1, 2, 3};
    want_e = '{0, 0, 0, 1, 0, 0, 0, 1};
    compare_obs("sawtooth");

    drive(0, 0, 1, 0, 0, 0, 3, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 0);
    repeat (13) drive(0, 1, 0, 0, 1);
    want_c = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0};
    want_e = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    compare_obs("updown");

    drive(0, 1, 1, 1, 0, 0, 7, 1);
    repeat (4) drive(0, 1, 0, 0, 1);
    drive(0, 1, 1, 0, 1, 2, 4, 1);
    repeat (8) drive(0, 1, 0, 0, 1);
    want_c = '{0, 1, 2, 3, 4, 5, 6, 7, 2, 3, 4, 2, 3};
    want_e = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
    compare_obs("shadow");

    drive(0, 0, 1, 0, 0, 5, 5, 1);
    drive(0, 0, 0, 0, 0);
    repeat (3) drive(0, 1, 0, 0, 1);
    drive(0, 1, 1, 0, 1, 9, 4, 1);
    repeat (3) drive(0, 1, 0, 0, 1);
    want_c = '{5, 5, 5, 5, 9, 9, 9};
    want_e = '{1, 1, 1, 1, 1, 1, 1};
    compare_obs("degenerate");

    drive(0, 0, 1, 1, 0, 0, 15, 1);
    for (int i = 0; i < 21; i++) drive(0, 1, 0, 0, (i % 3) == 2);
    repeat (10) drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, (i % 3) == 2);
    want_c = '{0, 1, 2, 3, 4, 5, 6, 7};
    want_e = '{0, 0, 0, 0, 0, 0, 0, 0};
    compare_obs("gated");

    drive(0, 1, 1, 1, 0, 0, 3, 0);
    repeat (5) drive(0, 1, 0, 0, 1);
    drive(0, 1, 0, 1, 1);
    repeat (3) drive(0, 1, 0, 0, 1);
    want_c = '{0, 1, 2, 3, 2, 0, 1, 2};
    want_e = '{0, 0, 0, 0, 0, 0, 0, 0};
    compare_obs("restart");
    drive(1, 1, 0, 0, 1);
    check_reset("midreset");
    drive(0, 1, 0, 0, 1);

    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0,
            $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 6,
            int'($urandom_range(0, 10)), int'($urandom_range(0, 12)), $urandom_range(0, 1) == 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("scoreboard drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
